spram_arbiter: RTL and testbench

SPRAM_ARBITER -- requirements
Module: spram_arbiter

---
 rtl/spram_arbiter_pkg.sv | 8 +
 rtl/spram_arbiter_if.sv | 30 +++
 rtl/spram_arbiter_rr_arb2.sv | 18 +
 rtl/spram_arbiter.sv | 59 +++++
 tb/tb_spram_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/spram_arbiter_pkg.sv
// spram_arbiter_pkg: shared RAM geometry defaults and the round-robin pick helper
package spram_arbiter_pkg;
  localparam int A_W_DEF = 9;
  localparam int D_W_DEF = 32;
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    return &req ? (last ? 2'b01 : 2'b10) : req;
  endfunction
endpackage

// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if: requester, flush and RAM-port bundle with arbiter (slave) and environment (master) views
interface spram_arbiter_if import spram_arbiter_pkg::*; #(
  parameter int A_W = A_W_DEF,
  parameter int D_W = D_W_DEF
);
  logic req0_valid, req0_we, req0_ready, rsp0_valid;
  logic req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [A_W-1:0] req0_addr, req1_addr, ram_addr;
  logic [D_W-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, ram_din, ram_dout;
  logic flush_req, flush_busy, flush_done;
  logic ram_ena, ram_wea, ram_flush, ram_read_valid;
  modport slave (
    input req0_valid, req0_we, req0_addr, req0_wdata,
    input req1_valid, req1_we, req1_addr, req1_wdata,
    input flush_req, ram_dout, ram_read_valid,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output flush_busy, flush_done,
    output ram_ena, ram_wea, ram_flush, ram_addr, ram_din
  );
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output flush_req, ram_dout, ram_read_valid,
    input req0_ready, rsp0_valid, rsp0_rdata,
    input req1_ready, rsp1_valid, rsp1_rdata,
    input flush_busy, flush_done,
    input ram_ena, ram_wea, ram_flush, ram_addr, ram_din
  );
endinterface

// File: rtl/spram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; last_grant moves only when a grant is issued
module rr_arb2 import spram_arbiter_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  always_comb begin
    gnt_o = en_i ? rr_pick(req_i, last_q) : 2'b00;
    last_d = |gnt_o ? gnt_o[1] : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: two-requester round-robin front end for a single-port RAM with a one-shot flush sequence
module spram_arbiter import spram_arbiter_pkg::*; #(
  parameter int A_W = A_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input logic clk,
  input logic rst,
  spram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {SERVE, FLUSH, DONE} state_e;
  state_e state_q, state_d;
  logic pending_q, pending_d, tag_q, tag_d, serve, sel, wea, rd_acc, ena;
  logic [1:0] gnt;
  logic [A_W-1:0] addr_sel;
  logic [D_W-1:0] din_sel;
  rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .en_i(serve),
    .req_i({bus.req1_valid, bus.req0_valid}),
    .gnt_o(gnt)
  );
  always_comb begin
    serve = ~rst & (state_q == SERVE) & ~bus.flush_req;
    sel = gnt[1];
    ena = |gnt;
    addr_sel = sel ? bus.req1_addr : bus.req0_addr;
    din_sel = sel ? bus.req1_wdata : bus.req0_wdata;
    wea = ena & (sel ? bus.req1_we : bus.req0_we);
    rd_acc = ena & ~wea;
    pending_d = rd_acc;
    tag_d = rd_acc ? sel : tag_q;
    state_d = state_q == SERVE ? (bus.flush_req ? FLUSH : SERVE) : state_q == FLUSH ? DONE : SERVE;
    bus.req0_ready = gnt[0];
    bus.req1_ready = gnt[1];
    bus.ram_ena = ena;
    bus.ram_wea = wea;
    bus.ram_addr = ena ? addr_sel : '0;
    bus.ram_din = ena ? din_sel : '0;
    bus.rsp0_valid = ~rst & bus.ram_read_valid & pending_q & ~tag_q;
    bus.rsp1_valid = ~rst & bus.ram_read_valid & pending_q & tag_q;
    bus.rsp0_rdata = rst ? '0 : bus.ram_dout;
    bus.rsp1_rdata = rst ? '0 : bus.ram_dout;
    bus.ram_flush = ~rst & (state_q == FLUSH);
    bus.flush_done = ~rst & (state_q == DONE);
    bus.flush_busy = ~rst & (state_q != SERVE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SERVE;
      pending_q <= 1'b0;
      tag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      tag_q <= tag_d;
    end
  end
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed scenarios plus random traffic checked every cycle against a behavioural model
module tb_spram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  spram_arbiter_if bus ();
  spram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] ram [512];
  always @(posedge clk) begin
    if (rst) bus.ram_read_valid <= 1'b0;
    else begin
      bus.ram_read_valid <= bus.ram_ena & ~bus.ram_wea;
      if (bus.ram_ena & ~bus.ram_wea) bus.ram_dout <= ram[bus.ram_addr];
      if (bus.ram_ena & bus.ram_wea) ram[bus.ram_addr] <= bus.ram_din;
      if (bus.ram_flush) for (int i = 0; i < 512; i++) ram[i] <= '0;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask
  int phase = 0;
  int m_last = 1;
  bit exp_rv = 0;
  int exp_who = 0;
  logic [31:0] exp_data = '0;
  logic [31:0] mm [512];
  int g;
  bit m_we;
  logic [8:0] m_addr;
  logic [31:0] m_din;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.flush_busy,
                      bus.flush_done, bus.ram_ena, bus.ram_wea, bus.ram_flush}, 0);
      chk("rst_bus", {bus.ram_addr, bus.ram_din}, 0);
      chk("rst_rdata", {bus.rsp0_rdata, bus.rsp1_rdata}, 0);
      phase = 0;
      m_last = 1;
      exp_rv = 0;
    end else begin
      g = -1;
      if (phase == 0 && !bus.flush_req) begin
        if (bus.req0_valid && bus.req1_valid) g = m_last == 1 ? 0 : 1;
        else if (bus.req0_valid) g = 0;
        else if (bus.req1_valid) g = 1;
      end
      chk("m_ready0", bus.req0_ready, g == 0);
      chk("m_ready1", bus.req1_ready, g == 1);
      chk("m_ena", bus.ram_ena, g >= 0);
      if (g >= 0) begin
        m_we = g == 1 ? bus.req1_we : bus.req0_we;
        m_addr = g == 1 ? bus.req1_addr : bus.req0_addr;
        m_din = g == 1 ? bus.req1_wdata : bus.req0_wdata;
        chk("m_wea", bus.ram_wea, m_we);
        chk("m_addr", bus.ram_addr, m_addr);
        if (m_we) chk("m_din", bus.ram_din, m_din);
      end else chk("m_wea_idle", bus.ram_wea, 0);
      chk("m_rsp0", bus.rsp0_valid, exp_rv && exp_who == 0);
      chk("m_rsp1", bus.rsp1_valid, exp_rv && exp_who == 1);
      if (exp_rv) chk("m_rdata", exp_who == 1 ? bus.rsp1_rdata : bus.rsp0_rdata, exp_data);
      chk("m_ram_flush", bus.ram_flush, phase == 1);
      chk("m_flush_done", bus.flush_done, phase == 2);
      chk("m_flush_busy", bus.flush_busy, phase != 0);
      exp_rv = 0;
      if (g >= 0) begin
        m_last = g;
        if (m_we) mm[m_addr] = m_din;
        else begin
          exp_rv = 1;
          exp_who = g;
          exp_data = mm[m_addr];
        end
      end
      if (phase == 1) for (int i = 0; i < 512; i++) mm[i] = '0;
      phase = phase == 0 ? (bus.flush_req ? 1 : 0) : phase == 1 ? 2 : 0;
    end
  end
  task automatic drv(input int n, input logic v, input logic we, input logic [8:0] a, input logic [31:0] d);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    bus.flush_req = 0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  logic [1:0] prev;
  int done_cnt;
  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = '0;
      mm[i] = '0;
    end
    bus.ram_dout = '0;
    rst = 1;
    idle();
    neg();
    chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    repeat (2) cyc();
    rst = 0;
    drv(0, 1, 1, 5, 32'hDEADBEEF);
    neg();
    chk("s1_wr_ready0", bus.req0_ready, 1);
    cyc();
    drv(0, 0, 0, 0, 0);
    drv(1, 1, 0, 5, 0);
    neg();
    chk("s1_rd_ready1", bus.req1_ready, 1);
    cyc();
    idle();
    neg();
    chk("s1_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b10);
    chk("s1_rdata", bus.rsp1_rdata, 32'hDEADBEEF);
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      cyc();
      drv(0, 1, 0, 9'(i), 0);
      drv(1, 1, 0, 9'(i + 16), 0);
      neg();
      chk("s2_gnt", {bus.req1_ready, bus.req0_ready}, i % 2 == 1 ? 2'b10 : 2'b01);
      if (i > 0) chk("s2_rsp_tag", {bus.rsp1_valid, bus.rsp0_valid}, prev);
      prev = {bus.req1_ready, bus.req0_ready};
    end
    cyc();
    idle();
    neg();
    chk("s2_last_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b10);
    cyc();
    drv(0, 1, 1, 7, 32'h1234);
    neg();
    chk("s3_wr", bus.req0_ready, 1);
    cyc();
    bus.flush_req = 1;
    drv(0, 1, 0, 7, 0);
    neg();
    chk("s3_blocked", {bus.req0_ready, bus.ram_ena}, 0);
    cyc();
    bus.flush_req = 0;
    neg();
    chk("s3_flush", {bus.ram_flush, bus.flush_busy, bus.req0_ready}, 3'b110);
    cyc();
    neg();
    chk("s3_done", {bus.flush_done, bus.ram_flush, bus.req0_ready}, 3'b100);
    cyc();
    neg();
    chk("s3_accept", bus.req0_ready, 1);
    cyc();
    idle();
    neg();
    chk("s3_rsp", bus.rsp0_valid, 1);
    chk("s3_cleared", bus.rsp0_rdata, 0);
    cyc();
    drv(1, 1, 1, 9, 32'hA5A5);
    neg();
    chk("s4_wr", bus.req1_ready, 1);
    cyc();
    drv(1, 1, 0, 9, 0);
    neg();
    chk("s4_rd", bus.req1_ready, 1);
    cyc();
    idle();
    bus.flush_req = 1;
    neg();
    chk("s4_rsp", bus.rsp1_valid, 1);
    chk("s4_rdata", bus.rsp1_rdata, 32'hA5A5);
    cyc();
    bus.flush_req = 0;
    repeat (2) cyc();
    done_cnt = 0;
    bus.flush_req = 1;
    neg();
    chk("s5_serve", bus.flush_busy, 0);
    cyc();
    neg();
    chk("s5_flush", bus.ram_flush, 1);
    done_cnt += int'(bus.flush_done);
    cyc();
    neg();
    done_cnt += int'(bus.flush_done);
    cyc();
    bus.flush_req = 0;
    neg();
    done_cnt += int'(bus.flush_done);
    chk("s5_back", bus.flush_busy, 0);
    cyc();
    neg();
    done_cnt += int'(bus.flush_done);
    chk("s5_one_done", done_cnt, 1);
    cyc();
    drv(0, 1, 0, 3, 0);
    neg();
    chk("s6_rd", bus.req0_ready, 1);
    cyc();
    idle();
    rst = 1;
    neg();
    chk("s6_no_rsp_rst", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    cyc();
    rst = 0;
    drv(0, 1, 0, 1, 0);
    drv(1, 1, 0, 2, 0);
    neg();
    chk("s6_no_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("s6_gnt", {bus.req1_ready, bus.req0_ready}, 2'b01);
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst = $urandom_range(0, 99) == 0;
      bus.flush_req = $urandom_range(0, 29) == 0;
      drv(0, $urandom_range(0, 9) < 6, 1'($urandom), 9'($urandom_range(0, 15)), $urandom);
      drv(1, $urandom_range(0, 9) < 6, 1'($urandom), 9'($urandom_range(0, 15)), $urandom);
    end
    cyc();
    rst = 0;
    idle();
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
